// File: rtl/mha_pkg.sv
// Shared MHA datapath definitions: widths, attention-value FSM states and the
// accumulator-to-Q2.13 conversion. ATTN_ROUND_EN selects round-half-up instead of floor.
package mha_pkg;

   localparam int D_W    = 16;
   localparam int FRAC_W = 13;
   localparam int NUM    = 4;
   localparam int DIM    = 4;
   localparam int CNT_W  = (NUM > 1) ? $clog2(NUM) : 1;
   localparam int ACC_W  = 2 * D_W + $clog2(NUM);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      OUT  = 2'd2
   } state_e;

   // Clamp bounds carry one extra bit so the rounding add can never wrap.
   localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W + 2 - D_W){1'b0}}, {(D_W - 1){1'b1}}};
   localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W + 2 - D_W){1'b1}}, {(D_W - 1){1'b0}}};
`ifdef ATTN_ROUND_EN
   localparam logic signed [ACC_W:0] RND_HALF = {{(ACC_W - FRAC_W + 1){1'b0}}, 1'b1, {(FRAC_W - 1){1'b0}}};
`endif

   function automatic logic [D_W-1:0] sat_round(input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W:0] ext;
      ext = {acc[ACC_W-1], acc};
`ifdef ATTN_ROUND_EN
      ext = ext + RND_HALF;
`endif
      ext = ext >>> FRAC_W;
      if (ext > SAT_MAX) begin
         return SAT_MAX[D_W-1:0];
      end else if (ext < SAT_MIN) begin
         return SAT_MIN[D_W-1:0];
      end else begin
         return ext[D_W-1:0];
      end
   endfunction

endpackage

// File: rtl/attn_mac_lane.sv
// One output-dimension MAC lane: accumulates P*V products (Q4.26) and presents
// the rounded/saturated Q2.13 value of its accumulator.
module attn_mac_lane
   import mha_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           clr,
   input  logic           en,
   input  logic [D_W-1:0] p_op,
   input  logic [D_W-1:0] v_op,
   output logic [D_W-1:0] res
);

   logic signed [2*D_W-1:0] prod;
   logic signed [ACC_W-1:0] acc_d;
   logic signed [ACC_W-1:0] acc_q;

   always_comb begin
      prod  = $signed(p_op) * $signed(v_op);
      acc_d = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = acc_q + ACC_W'(prod);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign res = sat_round(acc_q);

endmodule

// File: rtl/attn_value_mac.sv
// Attention-value stage: latches one probability vector, accumulates NUM value rows
// into DIM lanes and emits O = sum_j P[j]*V[j] as Q2.13. Rounding mode: ATTN_ROUND_EN.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// valid is ignored while ready is low. Vectors are packed with element 0 in the LSBs.
module attn_value_mac
   import mha_pkg::*;
(
   input  logic                 I_CLK,
   input  logic                 I_RST,
   input  logic                 I_P_VLD,
   output logic                 O_P_RDY,
   input  logic [NUM*D_W-1:0]   I_P,
   input  logic                 I_V_VLD,
   output logic                 O_V_RDY,
   input  logic [DIM*D_W-1:0]   I_V,
   output logic                 O_VLD,
   output logic [DIM*D_W-1:0]   O_DATA,
   output logic [1:0]           O_DBG_STATE
);

   state_e               state_d, state_q;
   logic [CNT_W-1:0]     cnt_d, cnt_q;
   logic [NUM*D_W-1:0]   p_d, p_q;
   logic                 o_vld_d, o_vld_q;
   logic [DIM*D_W-1:0]   o_data_d, o_data_q;
   logic                 lane_clr;
   logic                 lane_en;
   logic [D_W-1:0]       p_sel;
   logic [DIM*D_W-1:0]   lane_res;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      p_d      = p_q;
      o_vld_d  = 1'b0;
      o_data_d = o_data_q;
      lane_clr = 1'b0;
      lane_en  = 1'b0;
      O_P_RDY  = 1'b0;
      O_V_RDY  = 1'b0;
      p_sel    = p_q[int'(cnt_q) * D_W +: D_W];
      case (state_q)
         IDLE: begin
            O_P_RDY = 1'b1;
            if (I_P_VLD) begin
               p_d      = I_P;
               cnt_d    = '0;
               lane_clr = 1'b1;
               state_d  = ACC;
            end
         end
         ACC: begin
            O_V_RDY = 1'b1;
            if (I_V_VLD) begin
               lane_en = 1'b1;
               if (cnt_q == CNT_W'(NUM - 1)) begin
                  cnt_d   = '0;
                  state_d = OUT;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         OUT: begin
            // Lanes are idle here, so their outputs already hold the final sums.
            o_vld_d  = 1'b1;
            o_data_d = lane_res;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge I_CLK or posedge I_RST) begin
      if (I_RST) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         p_q      <= '0;
         o_vld_q  <= 1'b0;
         o_data_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         p_q      <= p_d;
         o_vld_q  <= o_vld_d;
         o_data_q <= o_data_d;
      end
   end

   for (genvar d = 0; d < DIM; d++) begin : g_lane
      attn_mac_lane u_lane (
         .clk  (I_CLK),
         .rst  (I_RST),
         .clr  (lane_clr),
         .en   (lane_en),
         .p_op (p_sel),
         .v_op (I_V[d*D_W +: D_W]),
         .res  (lane_res[d*D_W +: D_W])
      );
   end

   assign O_VLD       = o_vld_q;
   assign O_DATA      = o_data_q;
   assign O_DBG_STATE = state_q;

endmodule

// File: tb/tb_attn_value_mac.sv
// Self-checking bench for attn_value_mac: directed corner vectors plus random vectors
// with random V gaps, compared against an arithmetic model of O[d] = sum P[j]*V[j][d].
module tb_attn_value_mac;
   import mha_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 p_vld;
   logic                 p_rdy;
   logic [NUM*D_W-1:0]   p_bus;
   logic                 v_vld;
   logic                 v_rdy;
   logic [DIM*D_W-1:0]   v_bus;
   logic                 o_vld;
   logic [DIM*D_W-1:0]   o_data;
   logic [1:0]           dbg_state;

   int errors = 0;
   int checks = 0;

   logic signed [D_W-1:0] p_arr [NUM];
   logic signed [D_W-1:0] v_arr [NUM][DIM];
   logic [D_W-1:0]        exp_q [$];

   attn_value_mac dut (
      .I_CLK       (clk),
      .I_RST       (rst),
      .I_P_VLD     (p_vld),
      .O_P_RDY     (p_rdy),
      .I_P         (p_bus),
      .I_V_VLD     (v_vld),
      .O_V_RDY     (v_rdy),
      .I_V         (v_bus),
      .O_VLD       (o_vld),
      .O_DATA      (o_data),
      .O_DBG_STATE (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: exact sum, then rounding/floor, then clamp to 16-bit signed.
   function automatic logic [D_W-1:0] model_elem(input int d);
      longint s = 0;
      for (int j = 0; j < NUM; j++) begin
         s += longint'(p_arr[j]) * longint'(v_arr[j][d]);
      end
`ifdef ATTN_ROUND_EN
      s += 4096;
`endif
      s = s >>> 13;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return 16'(s);
   endfunction

   function automatic logic [NUM*D_W-1:0] pack_p();
      logic [NUM*D_W-1:0] r;
      for (int j = 0; j < NUM; j++) r[j*D_W +: D_W] = p_arr[j];
      return r;
   endfunction

   function automatic logic [DIM*D_W-1:0] pack_v(input int j);
      logic [DIM*D_W-1:0] r;
      for (int d = 0; d < DIM; d++) r[d*D_W +: D_W] = v_arr[j][d];
      return r;
   endfunction

   function automatic logic [DIM*D_W-1:0] rand_bus();
      logic [DIM*D_W-1:0] r;
      for (int d = 0; d < DIM; d++) r[d*D_W +: D_W] = 16'($urandom);
      return r;
   endfunction

   task automatic run_vec(input string tag, input int gap_max, input bit poke_p);
      int n;
      logic [D_W-1:0] exp_v [DIM];
      for (int d = 0; d < DIM; d++) exp_q.push_back(model_elem(d));
      n = 0;
      @(negedge clk);
      while (!p_rdy && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_p_rdy"}, 64'(p_rdy), 1);
      p_bus = pack_p();
      p_vld = 1'b1;
      @(posedge clk);
      #1;
      p_vld = poke_p;
      p_bus = rand_bus();
      for (int j = 0; j < NUM; j++) begin
         int gaps = $urandom_range(gap_max, 0);
         for (int g = 0; g < gaps; g++) begin
            v_bus = rand_bus();
            @(posedge clk);
            #1;
         end
         v_bus = pack_v(j);
         v_vld = 1'b1;
         @(negedge clk);
         check({tag, "_v_rdy"}, 64'(v_rdy), 1);
         @(posedge clk);
         #1;
         v_vld = 1'b0;
         v_bus = rand_bus();
      end
      p_vld = 1'b0;
      @(negedge clk);
      check({tag, "_out_vld"}, 64'(o_vld), 0);
      check({tag, "_out_p_rdy"}, 64'(p_rdy), 0);
      check({tag, "_out_v_rdy"}, 64'(v_rdy), 0);
      @(negedge clk);
      check({tag, "_vld"}, 64'(o_vld), 1);
      for (int d = 0; d < DIM; d++) begin
         exp_v[d] = exp_q.pop_front();
         check($sformatf("%s_data%0d", tag, d), 64'($signed(o_data[d*D_W +: D_W])), 64'($signed(exp_v[d])));
      end
      @(negedge clk);
      check({tag, "_vld_drop"}, 64'(o_vld), 0);
      for (int d = 0; d < DIM; d++) begin
         check($sformatf("%s_hold%0d", tag, d), 64'($signed(o_data[d*D_W +: D_W])), 64'($signed(exp_v[d])));
      end
   endtask

   initial begin
      rst   = 1'b1;
      p_vld = 1'b0;
      v_vld = 1'b0;
      p_bus = '0;
      v_bus = '0;
      #1;
      check("rst_p_rdy", 64'(p_rdy), 1);
      check("rst_v_rdy", 64'(v_rdy), 0);
      check("rst_vld", 64'(o_vld), 0);
      check("rst_data", 64'(o_data), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int j = 0; j < NUM; j++) begin
         p_arr[j] = 16'sd2048;
         for (int d = 0; d < DIM; d++) v_arr[j][d] = 16'sd8192;
      end
      run_vec("uniform", 0, 0);

      p_arr[0] = 16'sd8192;
      for (int j = 1; j < NUM; j++) p_arr[j] = 16'sd0;
      v_arr[0][0] = 16'sd4096;
      v_arr[0][1] = -16'sd4096;
      v_arr[0][2] = 16'sd1;
      v_arr[0][3] = -16'sd1;
      for (int j = 1; j < NUM; j++)
         for (int d = 0; d < DIM; d++) v_arr[j][d] = 16'($urandom);
      run_vec("onehot", 0, 0);

      for (int j = 0; j < NUM; j++) begin
         p_arr[j] = 16'sd8192;
         for (int d = 0; d < DIM; d++) v_arr[j][d] = 16'sd28672;
      end
      run_vec("sat_pos", 0, 0);
      for (int j = 0; j < NUM; j++)
         for (int d = 0; d < DIM; d++) v_arr[j][d] = -16'sd32768;
      run_vec("sat_neg", 0, 0);

      p_arr[0] = 16'sd1;
      for (int j = 1; j < NUM; j++) p_arr[j] = 16'sd0;
      for (int j = 0; j < NUM; j++)
         for (int d = 0; d < DIM; d++) v_arr[j][d] = 16'sd4096;
      run_vec("round", 0, 0);

      for (int j = 0; j < NUM; j++) begin
         p_arr[j] = 16'($urandom_range(8192, 0));
         for (int d = 0; d < DIM; d++) v_arr[j][d] = 16'($urandom);
      end
      run_vec("gap_ref", 0, 0);
      run_vec("gap", 3, 0);
      run_vec("p_poke", 2, 1);

      // V valid while idle must not be consumed.
      @(posedge clk);
      #1;
      v_vld = 1'b1;
      v_bus = rand_bus();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("idle_v_rdy", 64'(v_rdy), 0);
      end
      @(posedge clk);
      #1;
      v_vld = 1'b0;
      run_vec("after_idle_v", 1, 0);

      // Abort a vector after two beats with an asynchronous reset.
      p_bus = rand_bus();
      p_vld = 1'b1;
      @(posedge clk);
      #1;
      p_vld = 1'b0;
      for (int j = 0; j < 2; j++) begin
         v_bus = rand_bus();
         v_vld = 1'b1;
         @(posedge clk);
         #1;
      end
      v_vld = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("abort_vld", 64'(o_vld), 0);
      check("abort_data", 64'(o_data), 0);
      check("abort_p_rdy", 64'(p_rdy), 1);
      check("abort_v_rdy", 64'(v_rdy), 0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("abort_no_vld", 64'(o_vld), 0);
      end
      run_vec("post_abort", 0, 0);

      for (int t = 0; t < 12; t++) begin
         for (int j = 0; j < NUM; j++) begin
            p_arr[j] = (t % 2 == 0) ? 16'($urandom_range(8192, 0)) : 16'($urandom);
            for (int d = 0; d < DIM; d++) v_arr[j][d] = 16'($urandom);
         end
         run_vec($sformatf("rand%0d", t), 3, (t % 3) == 0);
      end

      check("queue_empty", 64'(exp_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
